mux_bus_demux: RTL and testbench
================================

Name: mux_bus_demux

Overview:
- Receiving end of a time-multiplexed 2:1 bus. The source drives the A half or the B half of a word onto one shared WIDTH-bit bus, chosen by a select line and qualified by an active-low enable.
- This block captures each half into staging, reassembles complete A/B pairs, and presents them to the consumer with a valid/ready handshake.
- It sits between the bus pins and downstream datapath logic, and provides one pair of buffering plus sticky overrun detection.

Parameters:
- WIDTH, 4, width of each half and of the shared bus.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- bus_in  input  WIDTH  shared multiplexed bus data.
- bus_sel  input  1  0 = bus carries the A half; 1 = bus carries the B half.
- bus_enb_n  input  1  active-low strobe; a half is captured only on an edge where this is 0.
- pair_ready  input  1  consumer accepts the output pair.
- overrun_clr  input  1  synchronous clear of overrun.
- a_out  output  WIDTH  reassembled A half.
- b_out  output  WIDTH  reassembled B half.
- pair_valid  output  1  a_out/b_out hold an unconsumed pair.
- overrun  output  1  sticky flag: a half was dropped.
- a_held  output  1  staging holds an A half not yet paired.
- b_held  output  1  staging holds a B half not yet paired.

Behaviour:
- Reset (async, immediate): state IDLE; a_out, b_out, staging = 0; pair_valid, overrun, a_held, b_held = 0. Reset mid-pair discards partial halves.
- Capture: on an edge with bus_enb_n = 0, bus_in is a "half event" of type A (bus_sel = 0) or B (bus_sel = 1). With bus_enb_n = 1, nothing is captured.
- Output slot "free" on an edge means pair_valid = 0, or pair_valid & pair_ready = 1. A pair is consumed on any edge with pair_valid & pair_ready.
- States:
  - IDLE: A event -> stage A, go GOT_A. B event -> stage B, go GOT_B.
  - GOT_A:
    - A event: overwrite staged A (latest wins), stay GOT_A, no overrun.
    - B event, slot free: a_out <= staged A, b_out <= bus_in, pair_valid <= 1, go IDLE.
    - B event, slot not free: stage B, go STALL.
  - GOT_B: symmetric to GOT_A with A and B swapped.
  - STALL (both halves staged, output occupied):
    - Slot free: move staged pair to the output, pair_valid <= 1.
    - Simultaneous half event while the slot frees: the new half is staged; next state GOT_A or GOT_B. No overrun.
    - Slot free, no event: go IDLE.
    - Half event while the slot is not free: the event is dropped, overrun <= 1, stay STALL, staging unchanged.
- pair_valid clears on consumption unless a new pair loads on the same edge, in which case it stays 1 with the new data.
- Latency: the pair appears on outputs one edge after the completing half is presented, when the slot is free. Sustained throughput is 1 pair per 2 cycles.
- overrun:
  - Set only by a drop in STALL.
  - Cleared by overrun_clr on an edge.
  - If a drop and overrun_clr occur on the same edge, set wins.
- a_held = state is GOT_A or STALL; b_held = state is GOT_B or STALL. Both are registered.
- a_out and b_out change only when a pair loads. They hold their value after consumption.

Test Plan:
- Reset, then A = 0x3, then B = 0xC with pair_ready = 1 -> after the B edge: a_out = 0x3, b_out = 0xC, pair_valid = 1; the next edge clears pair_valid.
- B = 0x5 first, then A = 0xA -> pair a_out = 0xA, b_out = 0x5. a_held stays 0 throughout; b_held = 1 for one cycle.
- A = 0x1, A = 0x7, then B = 0x2 -> a_out = 0x7 (latest wins), overrun = 0.
- pair_ready = 0: pair (1,2) loads, then A = 3, B = 4 -> STALL with a_held = b_held = 1. A third half A = 5 -> overrun = 1, dropped. Raise pair_ready -> (1,2) consumed, then (3,4) presented. Pulse overrun_clr -> overrun = 0.
- In STALL, pair_ready = 1 and an A = 0x9 event on the same edge -> staged pair moves to the output, state GOT_A, overrun stays 0.
- Assert reset asynchronously between edges while in GOT_A with pair_valid = 1 -> all outputs 0 immediately. A following B event yields GOT_B, not a pair.

Source files
------------

// File: rtl/mux_bus_demux.sv
// Receiver for a time-multiplexed 2:1 bus: stages A/B halves, reassembles pairs,
// and hands them to the consumer over valid/ready with sticky overrun detection.
module mux_bus_demux #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_sel,
    input  logic             bus_enb_n,
    input  logic             pair_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             pair_valid,
    output logic             overrun,
    output logic             a_held,
    output logic             b_held
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        GOT_B = 2'd2,
        STALL = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stage_a_q, stage_a_d;
    logic [WIDTH-1:0] stage_b_q, stage_b_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] b_out_q, b_out_d;
    logic             pair_valid_q, pair_valid_d;
    logic             overrun_q, overrun_d;
    logic             a_held_q, b_held_q;

    logic ev_a, ev_b, consume, slot_free;

    assign ev_a      = ~bus_enb_n & ~bus_sel;
    assign ev_b      = ~bus_enb_n &  bus_sel;
    assign consume   = pair_valid_q & pair_ready;
    assign slot_free = ~pair_valid_q | pair_ready;

    always_comb begin
        state_d      = state_q;
        stage_a_d    = stage_a_q;
        stage_b_d    = stage_b_q;
        a_out_d      = a_out_q;
        b_out_d      = b_out_q;
        pair_valid_d = pair_valid_q & ~consume;
        overrun_d    = overrun_q & ~overrun_clr;

        unique case (state_q)
            IDLE: begin
                if (ev_a) begin
                    stage_a_d = bus_in;
                    state_d   = GOT_A;
                end else if (ev_b) begin
                    stage_b_d = bus_in;
                    state_d   = GOT_B;
                end
            end
            GOT_A: begin
                if (ev_a) begin
                    stage_a_d = bus_in;
                end else if (ev_b) begin
                    if (slot_free) begin
                        a_out_d      = stage_a_q;
                        b_out_d      = bus_in;
                        pair_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        stage_b_d = bus_in;
                        state_d   = STALL;
                    end
                end
            end
            GOT_B: begin
                if (ev_b) begin
                    stage_b_d = bus_in;
                end else if (ev_a) begin
                    if (slot_free) begin
                        a_out_d      = bus_in;
                        b_out_d      = stage_b_q;
                        pair_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        stage_a_d = bus_in;
                        state_d   = STALL;
                    end
                end
            end
            STALL: begin
                if (slot_free) begin
                    a_out_d      = stage_a_q;
                    b_out_d      = stage_b_q;
                    pair_valid_d = 1'b1;
                    // A half arriving as the slot frees starts the next pair.
                    if (ev_a) begin
                        stage_a_d = bus_in;
                        state_d   = GOT_A;
                    end else if (ev_b) begin
                        stage_b_d = bus_in;
                        state_d   = GOT_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ev_a | ev_b) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            stage_a_q    <= '0;
            stage_b_q    <= '0;
            a_out_q      <= '0;
            b_out_q      <= '0;
            pair_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            a_held_q     <= 1'b0;
            b_held_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_a_q    <= stage_a_d;
            stage_b_q    <= stage_b_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            pair_valid_q <= pair_valid_d;
            overrun_q    <= overrun_d;
            a_held_q     <= (state_d == GOT_A) || (state_d == STALL);
            b_held_q     <= (state_d == GOT_B) || (state_d == STALL);
        end
    end

    assign a_out      = a_out_q;
    assign b_out      = b_out_q;
    assign pair_valid = pair_valid_q;
    assign overrun    = overrun_q;
    assign a_held     = a_held_q;
    assign b_held     = b_held_q;

endmodule

// File: tb/tb_mux_bus_demux.sv
// Directed vector bench for mux_bus_demux: one clocked vector per edge, plus an
// asynchronous mid-cycle reset sequence.
module tb_mux_bus_demux;

    localparam int W = 4;
    localparam int NV = 28;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] bus_in;
    logic         bus_sel;
    logic         bus_enb_n;
    logic         pair_ready;
    logic         overrun_clr;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic         pair_valid;
    logic         overrun;
    logic         a_held;
    logic         b_held;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         enb_n;
        logic         sel;
        logic [W-1:0] bus;
        logic         rdy;
        logic         clr;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         epv;
        logic         eov;
        logic         eah;
        logic         ebh;
    } vec_t;

    vec_t vecs [NV];

    mux_bus_demux #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_in      (bus_in),
        .bus_sel     (bus_sel),
        .bus_enb_n   (bus_enb_n),
        .pair_ready  (pair_ready),
        .overrun_clr (overrun_clr),
        .a_out       (a_out),
        .b_out       (b_out),
        .pair_valid  (pair_valid),
        .overrun     (overrun),
        .a_held      (a_held),
        .b_held      (b_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic epv, input logic eov, input logic eah, input logic ebh);
        logic [2*W+3:0] got, exp;
        got = {a_out, b_out, pair_valid, overrun, a_held, b_held};
        exp = {ea, eb, epv, eov, eah, ebh};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got a=%h b=%h pv=%b ov=%b ah=%b bh=%b, required a=%h b=%h pv=%b ov=%b ah=%b bh=%b",
                     name, a_out, b_out, pair_valid, overrun, a_held, b_held,
                     ea, eb, epv, eov, eah, ebh);
        end else begin
            $display("ok   %s: a=%h b=%h pv=%b ov=%b ah=%b bh=%b",
                     name, a_out, b_out, pair_valid, overrun, a_held, b_held);
        end
    endtask

    task automatic drive(input logic enb_n, input logic sel, input logic [W-1:0] bus,
                         input logic rdy, input logic clr);
        bus_enb_n   = enb_n;
        bus_sel     = sel;
        bus_in      = bus;
        pair_ready  = rdy;
        overrun_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              enb sel bus    rdy clr   a      b    pv ov ah bh
        vecs[0]  = '{1'b0,1'b0,4'h3,1'b1,1'b0, 4'h0,4'h0, 1'b0,1'b0,1'b1,1'b0};
        vecs[1]  = '{1'b0,1'b1,4'hC,1'b1,1'b0, 4'h3,4'hC, 1'b1,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,4'h0,1'b1,1'b0, 4'h3,4'hC, 1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,4'h5,1'b1,1'b0, 4'h3,4'hC, 1'b0,1'b0,1'b0,1'b1};
        vecs[4]  = '{1'b0,1'b0,4'hA,1'b1,1'b0, 4'hA,4'h5, 1'b1,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,4'h0,1'b1,1'b0, 4'hA,4'h5, 1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,4'h1,1'b1,1'b0, 4'hA,4'h5, 1'b0,1'b0,1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b0,4'h7,1'b1,1'b0, 4'hA,4'h5, 1'b0,1'b0,1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b1,4'h2,1'b1,1'b0, 4'h7,4'h2, 1'b1,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,4'h0,1'b1,1'b0, 4'h7,4'h2, 1'b0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,4'h1,1'b0,1'b0, 4'h7,4'h2, 1'b0,1'b0,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,4'h2,1'b0,1'b0, 4'h1,4'h2, 1'b1,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b0,4'h3,1'b0,1'b0, 4'h1,4'h2, 1'b1,1'b0,1'b1,1'b0};
        vecs[13] = '{1'b0,1'b1,4'h4,1'b0,1'b0, 4'h1,4'h2, 1'b1,1'b0,1'b1,1'b1};
        vecs[14] = '{1'b0,1'b0,4'h5,1'b0,1'b0, 4'h1,4'h2, 1'b1,1'b1,1'b1,1'b1};
        vecs[15] = '{1'b1,1'b0,4'h0,1'b1,1'b0, 4'h3,4'h4, 1'b1,1'b1,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b0,4'h0,1'b1,1'b0, 4'h3,4'h4, 1'b0,1'b1,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b0,4'h0,1'b1,1'b1, 4'h3,4'h4, 1'b0,1'b0,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b0,4'h1,1'b0,1'b0, 4'h3,4'h4, 1'b0,1'b0,1'b1,1'b0};
        vecs[19] = '{1'b0,1'b1,4'h6,1'b0,1'b0, 4'h1,4'h6, 1'b1,1'b0,1'b0,1'b0};
        vecs[20] = '{1'b0,1'b0,4'h2,1'b0,1'b0, 4'h1,4'h6, 1'b1,1'b0,1'b1,1'b0};
        vecs[21] = '{1'b0,1'b1,4'h8,1'b0,1'b0, 4'h1,4'h6, 1'b1,1'b0,1'b1,1'b1};
        vecs[22] = '{1'b0,1'b0,4'h9,1'b1,1'b0, 4'h2,4'h8, 1'b1,1'b0,1'b1,1'b0};
        vecs[23] = '{1'b0,1'b1,4'hB,1'b0,1'b0, 4'h2,4'h8, 1'b1,1'b0,1'b1,1'b1};
        vecs[24] = '{1'b0,1'b0,4'hE,1'b0,1'b1, 4'h2,4'h8, 1'b1,1'b1,1'b1,1'b1};
        vecs[25] = '{1'b0,1'b1,4'hD,1'b1,1'b0, 4'h9,4'hB, 1'b1,1'b1,1'b0,1'b1};
        vecs[26] = '{1'b1,1'b0,4'h0,1'b1,1'b1, 4'h9,4'hB, 1'b0,1'b0,1'b0,1'b1};
        vecs[27] = '{1'b0,1'b0,4'hF,1'b0,1'b0, 4'hF,4'hD, 1'b1,1'b0,1'b0,1'b0};

        reset       = 1'b1;
        bus_in      = '0;
        bus_sel     = 1'b0;
        bus_enb_n   = 1'b1;
        pair_ready  = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check("idle_after_reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].enb_n, vecs[i].sel, vecs[i].bus, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb,
                  vecs[i].epv, vecs[i].eov, vecs[i].eah, vecs[i].ebh);
        end

        // Enter GOT_A with an unconsumed pair still on the output.
        drive(1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
        check("pre_reset_got_a", 4'hF, 4'hD, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check("async_reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        drive(1'b0, 1'b1, 4'h6, 1'b1, 1'b0);
        check("b_after_reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 4'h7, 1'b1, 1'b0);
        check("pair_after_reset", 4'h7, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
